// File: rtl/pipe_hazard_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Hazard-detect inputs and stall/flush control outputs shared
//                between the pipeline datapath (master) and the hazard
//                sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
    // ID / EX hazard detection inputs
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    // MEM-stage redirect and data-memory handshake
    logic       mem_take_branch;
    logic       mem_req;
    logic       mem_ready;
    // Register load enables
    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    // Bubble inserts
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       mem_wb_flush;
    // Status
    logic [1:0] state;
    logic       mem_timeout;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               mem_take_branch, mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               state, mem_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               mem_take_branch, mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               state, mem_timeout
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush sequencer for the 5-stage pipeline. Handles
//                load-use hazards, taken redirects resolved in MEM and
//                multi-cycle data-memory waits (with timeout guard).
//                Optional macro HAZARD_PERF_CNT_EN adds stall/flush cycle
//                counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,   // 1..7
    parameter int MEM_TIMEOUT  = 15   // 1..255
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flush_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MEM_WAIT   = 2'b10,
        ST_FLUSH      = 2'b11
    } state_t;

    localparam logic [2:0] c_fl_reload = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] c_wait_max  = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     r_saved;
    logic [7:0] r_wait_cnt;
    logic [2:0] r_fl_cnt;
    logic       r_timeout;

    state_t     w_state_n;
    state_t     w_saved_n;
    logic [7:0] w_wait_n;
    logic [2:0] w_fl_n;
    logic       w_timeout_set;

    logic       w_pc_en;
    logic       w_if_id_en;
    logic       w_id_ex_en;
    logic       w_ex_mem_en;
    logic       w_if_id_flush;
    logic       w_id_ex_flush;
    logic       w_ex_mem_flush;
    logic       w_mem_wb_flush;

    logic       w_load_use;
    logic       w_mem_stall;

    assign w_load_use  = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                         ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                          (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
    assign w_mem_stall = hz.mem_req && !hz.mem_ready;

    // Next-state and control outputs; reset overrides the controls last.
    always_comb begin
        w_state_n      = r_state;
        w_saved_n      = r_saved;
        w_wait_n       = r_wait_cnt;
        w_fl_n         = r_fl_cnt;
        w_timeout_set  = 1'b0;
        w_pc_en        = 1'b1;
        w_if_id_en     = 1'b1;
        w_id_ex_en     = 1'b1;
        w_ex_mem_en    = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_mem_wb_flush = 1'b0;

        case (r_state)
            ST_RUN, ST_LOAD_STALL: begin
                if (w_mem_stall) begin
                    // Freeze everything up to EX/MEM, bubble into WB.
                    w_pc_en        = 1'b0;
                    w_if_id_en     = 1'b0;
                    w_id_ex_en     = 1'b0;
                    w_ex_mem_en    = 1'b0;
                    w_mem_wb_flush = 1'b1;
                    w_saved_n      = ST_RUN;
                    w_wait_n       = 8'd1;
                    w_state_n      = ST_MEM_WAIT;
                end else if (hz.mem_take_branch) begin
                    // Kill the three younger wrong-path instructions.
                    w_if_id_flush  = 1'b1;
                    w_id_ex_flush  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_fl_n    = c_fl_reload;
                        w_state_n = ST_FLUSH;
                    end else begin
                        w_state_n = ST_RUN;
                    end
                end else if (w_load_use && (r_state == ST_RUN)) begin
                    // Hold PC and IF/ID, bubble into EX for one cycle.
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_id_ex_flush = 1'b1;
                    w_state_n     = ST_LOAD_STALL;
                end else begin
                    w_state_n = ST_RUN;
                end
            end

            ST_MEM_WAIT: begin
                if (hz.mem_ready) begin
                    w_state_n = r_saved;
                end else if (r_wait_cnt == c_wait_max) begin
                    // Forced release so a dead memory cannot hang the core.
                    w_timeout_set = 1'b1;
                    w_state_n     = r_saved;
                end else begin
                    w_pc_en        = 1'b0;
                    w_if_id_en     = 1'b0;
                    w_id_ex_en     = 1'b0;
                    w_ex_mem_en    = 1'b0;
                    w_mem_wb_flush = 1'b1;
                    w_wait_n       = r_wait_cnt + 8'd1;
                end
            end

            ST_FLUSH: begin
                if (w_mem_stall) begin
                    // Park the flush window; fl_cnt resumes after release.
                    w_pc_en        = 1'b0;
                    w_if_id_en     = 1'b0;
                    w_id_ex_en     = 1'b0;
                    w_ex_mem_en    = 1'b0;
                    w_mem_wb_flush = 1'b1;
                    w_saved_n      = ST_FLUSH;
                    w_wait_n       = 8'd1;
                    w_state_n      = ST_MEM_WAIT;
                end else if (hz.mem_take_branch) begin
                    w_if_id_flush  = 1'b1;
                    w_id_ex_flush  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                    w_fl_n         = c_fl_reload;
                    w_state_n      = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                end else begin
                    w_if_id_flush = 1'b1;
                    w_fl_n        = r_fl_cnt - 3'd1;
                    if (r_fl_cnt == 3'd1) begin
                        w_state_n = ST_RUN;
                    end
                end
            end

            default: begin
                w_state_n = ST_RUN;
            end
        endcase

        if (rst) begin
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_id_ex_en     = 1'b0;
            w_ex_mem_en    = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
            w_mem_wb_flush = 1'b1;
        end
    end

    // State, counters and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_saved    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_fl_cnt   <= 3'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_saved    <= w_saved_n;
            r_wait_cnt <= w_wait_n;
            r_fl_cnt   <= w_fl_n;
            r_timeout  <= r_timeout | w_timeout_set;
        end
    end

    assign hz.pc_en        = w_pc_en;
    assign hz.if_id_en     = w_if_id_en;
    assign hz.id_ex_en     = w_id_ex_en;
    assign hz.ex_mem_en    = w_ex_mem_en;
    assign hz.if_id_flush  = w_if_id_flush;
    assign hz.id_ex_flush  = w_id_ex_flush;
    assign hz.ex_mem_flush = w_ex_mem_flush;
    assign hz.mem_wb_flush = w_mem_wb_flush;
    assign hz.state        = r_state;
    assign hz.mem_timeout  = r_timeout & ~rst;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic        w_any_flush;

    assign w_any_flush = w_if_id_flush | w_id_ex_flush | w_ex_mem_flush | w_mem_wb_flush;

    // Saturating cycle counters for stalled-PC and bubble-insert cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= 32'd0;
            r_perf_flush <= 32'd0;
        end else begin
            if (!w_pc_en && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_any_flush && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flush_cycles = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl: directed hazard
//                scenarios followed by randomized traffic, compared against
//                a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int FC = 3;
    localparam int MT = 4;

    // Control vector layout: {pc,if_id,id_ex,ex_mem en, if_id,id_ex,ex_mem,mem_wb flush}
    localparam logic [7:0] c_running   = 8'b1111_0000;
    localparam logic [7:0] c_freeze    = 8'b0000_0001;
    localparam logic [7:0] c_redirect  = 8'b1111_1110;
    localparam logic [7:0] c_loadstall = 8'b0011_0100;
    localparam logic [7:0] c_flushing  = 8'b1111_1000;
    localparam logic [7:0] c_in_reset  = 8'b0000_1111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if u_if ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_cycles;
`endif

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES (FC),
        .MEM_TIMEOUT  (MT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (u_if.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cycles (perf_flush_cycles)
`endif
    );

    // Behavioural model: cycles spent waiting (0 = not waiting), remaining
    // flush-window cycles, whether the previous cycle issued a load stall,
    // and the sticky timeout.
    int  m_wait;
    int  m_fl;
    bit  m_shadow;
    bit  m_tmo;
    logic [31:0] m_pstall;
    logic [31:0] m_pflush;

    int  n_checks;
    int  n_pass;

    task automatic idle();
        u_if.id_rs1          = 5'd0;
        u_if.id_rs2          = 5'd0;
        u_if.id_uses_rs1     = 1'b0;
        u_if.id_uses_rs2     = 1'b0;
        u_if.ex_mem_read     = 1'b0;
        u_if.ex_rd           = 5'd0;
        u_if.mem_take_branch = 1'b0;
        u_if.mem_req         = 1'b0;
        u_if.mem_ready       = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Predict this cycle's outputs, compare, then advance the model past the edge.
    task automatic tick();
        logic [7:0] e_ctl;
        logic [1:0] e_st;
        logic [7:0] o_ctl;
        int  nw, nf;
        bit  ns, nt;
        bit  stall, lu;

        #2;
        stall = u_if.mem_req && !u_if.mem_ready;
        lu    = u_if.ex_mem_read && (u_if.ex_rd != 0) &&
                ((u_if.id_uses_rs1 && u_if.id_rs1 == u_if.ex_rd) ||
                 (u_if.id_uses_rs2 && u_if.id_rs2 == u_if.ex_rd));
        e_st  = (m_wait > 0) ? 2'd2 : (m_fl > 0) ? 2'd3 : m_shadow ? 2'd1 : 2'd0;
        nw = m_wait; nf = m_fl; ns = m_shadow; nt = m_tmo;

        if (rst) begin
            e_ctl = c_in_reset;
            nw = 0; nf = 0; ns = 0; nt = 0;
        end else if (m_wait > 0) begin
            if (u_if.mem_ready || m_wait == MT) begin
                e_ctl = c_running;
                if (!u_if.mem_ready) nt = 1;
                nw = 0;
            end else begin
                e_ctl = c_freeze;
                nw = m_wait + 1;
            end
        end else if (stall) begin
            e_ctl = c_freeze; nw = 1; ns = 0;
        end else if (u_if.mem_take_branch) begin
            e_ctl = c_redirect; nf = FC - 1; ns = 0;
        end else if (m_fl > 0) begin
            e_ctl = c_flushing; nf = m_fl - 1;
        end else if (lu && !m_shadow) begin
            e_ctl = c_loadstall; ns = 1;
        end else begin
            e_ctl = c_running; ns = 0;
        end

        o_ctl = {u_if.pc_en, u_if.if_id_en, u_if.id_ex_en, u_if.ex_mem_en,
                 u_if.if_id_flush, u_if.id_ex_flush, u_if.ex_mem_flush, u_if.mem_wb_flush};
        check("ctl", 32'(o_ctl), 32'(e_ctl));
        check("state", 32'(u_if.state), 32'(e_st));
        check("mem_timeout", 32'(u_if.mem_timeout), 32'((!rst) && m_tmo));
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall", perf_stall_cycles, m_pstall);
        check("perf_flush", perf_flush_cycles, m_pflush);
`endif

        @(posedge clk);
        if (rst) begin
            m_pstall = 32'd0;
            m_pflush = 32'd0;
        end else begin
            if (!e_ctl[7] && m_pstall != 32'hFFFF_FFFF) m_pstall = m_pstall + 32'd1;
            if ((|e_ctl[3:0]) && m_pflush != 32'hFFFF_FFFF) m_pflush = m_pflush + 32'd1;
        end
        m_wait = nw; m_fl = nf; m_shadow = ns; m_tmo = nt;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        idle();
        @(posedge clk);
        #1;
        m_wait = 0; m_fl = 0; m_shadow = 0; m_tmo = 0;
        m_pstall = 32'd0; m_pflush = 32'd0;

        // Reset state
        tick();
        rst = 1'b0;
        tick();

        // Load-use on rs2: stall, masked shadow cycle, back to RUN
        u_if.ex_mem_read = 1'b1; u_if.ex_rd = 5'd5;
        u_if.id_rs2 = 5'd5; u_if.id_uses_rs2 = 1'b1;
        tick();
        tick();
        idle();
        tick();

        // x0 destination never stalls
        u_if.ex_mem_read = 1'b1; u_if.ex_rd = 5'd0;
        u_if.id_rs1 = 5'd0; u_if.id_uses_rs1 = 1'b1;
        tick();
        tick();
        idle();

        // Taken redirect and the following flush window
        u_if.mem_take_branch = 1'b1;
        tick();
        u_if.mem_take_branch = 1'b0;
        repeat (FC) tick();

        // Memory wait released by mem_ready
        u_if.mem_req = 1'b1;
        repeat (3) tick();
        u_if.mem_ready = 1'b1;
        tick();
        idle();
        tick();

        // Memory wait forced out by the timeout; flag stays sticky
        u_if.mem_req = 1'b1;
        repeat (MT + 2) tick();
        idle();
        repeat (3) tick();

        // Simultaneous stall and branch: freeze only, branch taken after release
        u_if.mem_req = 1'b1; u_if.mem_take_branch = 1'b1;
        tick();
        u_if.mem_ready = 1'b1;
        tick();
        u_if.mem_req = 1'b0; u_if.mem_ready = 1'b0;
        tick();
        u_if.mem_take_branch = 1'b0;
        repeat (FC) tick();

        // Stall inside the flush window parks and resumes it
        u_if.mem_take_branch = 1'b1;
        tick();
        u_if.mem_take_branch = 1'b0;
        u_if.mem_req = 1'b1;
        repeat (2) tick();
        u_if.mem_ready = 1'b1;
        tick();
        idle();
        repeat (FC + 1) tick();

        // Reset mid-wait and mid-flush; timeout flag cleared
        u_if.mem_req = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        tick();
        u_if.mem_take_branch = 1'b1;
        tick();
        u_if.mem_take_branch = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic with hazard-friendly register ranges
        for (int i = 0; i < 3000; i++) begin
            u_if.id_rs1          = 5'($urandom_range(0, 3));
            u_if.id_rs2          = 5'($urandom_range(0, 3));
            u_if.id_uses_rs1     = 1'($urandom_range(0, 1));
            u_if.id_uses_rs2     = 1'($urandom_range(0, 1));
            u_if.ex_mem_read     = ($urandom_range(0, 99) < 40);
            u_if.ex_rd           = 5'($urandom_range(0, 3));
            u_if.mem_take_branch = ($urandom_range(0, 99) < 12);
            u_if.mem_req         = ($urandom_range(0, 99) < 30);
            u_if.mem_ready       = ($urandom_range(0, 99) < 45);
            rst                  = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
